// File: rtl/int_div_seq_pkg.sv
// Shared types and sign helpers for the divide sequencer that wraps the
// unsigned iterative divider core.
package int_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } div_seq_state_e;

  // Bit n is set when op encoding n is a signed operation (DIV, REM).
  localparam logic [3:0] OP_SIGNED_MASK = 4'b0101;

  // Helpers work on a wide container; callers size-cast back to WIDTH, which
  // yields the same WIDTH-bit modulo negation.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] abs_cond(input logic [MAX_W-1:0] x,
                                                 input logic            is_neg);
    return is_neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [MAX_W-1:0] neg_cond(input logic [MAX_W-1:0] x,
                                                 input logic            negate);
    return negate ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/int_div_seq_if.sv
// Request/response channels between the execute stage and the divide sequencer.
interface int_div_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [WIDTH-1:0] resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o
  );
endinterface

// File: rtl/int_div_seq.sv
// Signed/unsigned DIV/REM sequencer: normalises operands for an external
// unsigned divider core, applies sign fix-up and returns tagged results.
module int_div_seq
  import int_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  int_div_seq_if.slave     bus,
  input  logic             kill_i,
  output logic             div_start_o,
  output logic [WIDTH-1:0] div_n_o,
  output logic [WIDTH-1:0] div_d_o,
  input  logic [WIDTH-1:0] div_q_i,
  input  logic [WIDTH-1:0] div_r_i,
  input  logic             div_valid_i
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_seq_state_e   r_state;
  div_op_e          r_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;
  logic             r_start;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;

  logic             w_signed;
  logic             w_sign_a;
  logic             w_sign_b;
  logic             w_is_rem;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_accept;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_signed   = OP_SIGNED_MASK[bus.req_op_i];
  assign w_sign_a   = w_signed & bus.req_a_i[WIDTH-1];
  assign w_sign_b   = w_signed & bus.req_b_i[WIDTH-1];
  assign w_is_rem   = bus.req_op_i[1];
  assign w_div_zero = (bus.req_b_i == '0);
  assign w_ovf      = w_signed && (bus.req_a_i == MIN_NEG) && (bus.req_b_i == ALL_ONES);
  assign w_accept   = (r_state == IDLE) && bus.req_valid_i && !kill_i;

  // |min| wraps to min, which the core reads correctly as an unsigned magnitude.
  assign w_abs_a = WIDTH'(abs_cond(MAX_W'(bus.req_a_i), w_sign_a));
  assign w_abs_b = WIDTH'(abs_cond(MAX_W'(bus.req_b_i), w_sign_b));
  assign w_q_fix = WIDTH'(neg_cond(MAX_W'(div_q_i), r_sign_a ^ r_sign_b));
  assign w_r_fix = WIDTH'(neg_cond(MAX_W'(div_r_i), r_sign_a));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= IDLE;
      r_op         <= DIV;
      r_tag        <= '0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
      r_n          <= '0;
      r_d          <= '0;
      r_start      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= div_op_e'(bus.req_op_i);
            r_tag    <= bus.req_tag_i;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_n      <= w_abs_a;
            r_d      <= w_abs_b;
            if (w_div_zero) begin
              r_resp_data  <= w_is_rem ? bus.req_a_i : ALL_ONES;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else if (w_ovf) begin
              r_resp_data  <= w_is_rem ? '0 : bus.req_a_i;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        // The start pulse is already out, so a kill here must still drain the core.
        ISSUE: r_state <= kill_i ? DRAIN : WAIT;
        WAIT: begin
          if (kill_i) begin
            r_state <= div_valid_i ? IDLE : DRAIN;
          end else if (div_valid_i) begin
            r_resp_data  <= ((r_op == REM) || (r_op == REMU)) ? w_r_fix : w_q_fix;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (kill_i || bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        DRAIN: begin
          if (div_valid_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (r_state == IDLE);
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_data_o  = r_resp_data;
  assign bus.resp_tag_o   = r_tag;
  assign div_start_o      = r_start;
  assign div_n_o          = r_n;
  assign div_d_o          = r_d;

endmodule

// File: tb/tb_int_div_seq.sv
// Bench for int_div_seq with a behavioural unsigned divider core and a
// scoreboard of expected responses.
module tb_int_div_seq;
  import int_div_pkg::*;

  localparam int W   = 32;
  localparam int TW  = 5;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         kill = 1'b0;
  logic         div_valid = 1'b0;
  logic [W-1:0] div_q = '0;
  logic [W-1:0] div_r = '0;
  logic         start;
  logic [W-1:0] dn;
  logic [W-1:0] dd;

  int_div_seq_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  int_div_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i      (clk),
    .reset_i    (rst_n),
    .bus        (bus),
    .kill_i     (kill),
    .div_start_o(start),
    .div_n_o    (dn),
    .div_d_o    (dd),
    .div_q_i    (div_q),
    .div_r_i    (div_r),
    .div_valid_i(div_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           start_cnt = 0;
  int           core_cnt = 0;
  logic [W-1:0] core_n = '0;
  logic [W-1:0] core_d = '1;

  // Behavioural core: captures operands on start, pulses valid LAT cycles later.
  always @(posedge clk) begin
    #1;
    div_valid = 1'b0;
    if (!rst_n) begin
      core_cnt = 0;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          div_valid = 1'b1;
          div_q = core_n / core_d;
          div_r = core_n % core_d;
        end
      end
      if (start) begin
        start_cnt++;
        core_n = dn;
        core_d = dd;
        core_cnt = LAT;
      end
    end
  end

  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sa = a;
    sbv = b;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout req_ready=%b required 1", bus.req_ready_o);
    end
  endtask

  task automatic get_resp(output logic [W-1:0] d, output logic [TW-1:0] t);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    d = bus.resp_data_o;
    t = bus.resp_tag_o;
    if (ok) begin
      bus.resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready_i = 1'b0;
    end else begin
      total++;
      bad++;
      $display("FAIL resp_timeout resp_valid=%b required 1", bus.resp_valid_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_req_ready got=%b want=1", bus.req_ready_o);
    end
    total++;
    if ({bus.resp_valid_o, start, bus.resp_data_o, bus.resp_tag_o, dn, dd} !== '0) begin
      bad++;
      $display("FAIL reset_outputs vld=%b start=%b data=%h tag=%h n=%h d=%h want all 0",
               bus.resp_valid_o, start, bus.resp_data_o, bus.resp_tag_o, dn, dd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_signed();
    exp_t e;
    logic [W-1:0] d;
    logic [TW-1:0] t;
    int s0;
    s0 = start_cnt;
    e.data = 32'hFFFF_FFFD; e.tag = 5'd1; sb.push_back(e);
    send(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1);
    @(negedge clk);
    total++;
    if (start !== 1'b1 || dn !== 32'd7 || dd !== 32'd2) begin
      bad++;
      $display("FAIL div_issue start=%b n=%0d d=%0d want 1/7/2", start, dn, dd);
    end
    get_resp(d, t);
    e = sb.pop_front();
    total++;
    if (d !== e.data || t !== e.tag) begin
      bad++;
      $display("FAIL div_neg7_2 got=%h/%h want=%h/%h", d, t, e.data, e.tag);
    end
    total++;
    if (start_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL div_start_count got=%0d want=1", start_cnt - s0);
    end
    e.data = 32'hFFFF_FFFF; e.tag = 5'd2; sb.push_back(e);
    send(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd2);
    get_resp(d, t);
    e = sb.pop_front();
    total++;
    if (d !== e.data || t !== e.tag) begin
      bad++;
      $display("FAIL rem_neg7_2 got=%h/%h want=%h/%h", d, t, e.data, e.tag);
    end
  endtask

  task automatic test_unsigned();
    logic [1:0]   ops[2] = '{2'd1, 2'd3};
    logic [W-1:0] res[2] = '{32'd14, 32'd2};
    exp_t e;
    logic [W-1:0] d;
    logic [TW-1:0] t;
    for (int i = 0; i < 2; i++) begin
      e.data = res[i]; e.tag = 5'h13; sb.push_back(e);
      send(ops[i], 32'd100, 32'd7, 5'h13);
      get_resp(d, t);
      e = sb.pop_front();
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL unsigned_%0d got=%h/%h want=%h/%h", i, d, t, e.data, e.tag);
      end
    end
  endtask

  task automatic test_bypass();
    logic [1:0]   ops[5] = '{2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
    logic [W-1:0] as[5]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] bs[5]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] res[5] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
    int           nst[5] = '{0, 0, 0, 0, 1};
    exp_t e;
    logic [W-1:0] d;
    logic [TW-1:0] t;
    int s0;
    for (int i = 0; i < 5; i++) begin
      s0 = start_cnt;
      e.data = res[i]; e.tag = TW'(i + 4); sb.push_back(e);
      send(ops[i], as[i], bs[i], TW'(i + 4));
      if (nst[i] == 0) begin
        @(negedge clk);
        total++;
        if (bus.resp_valid_o !== 1'b1) begin
          bad++;
          $display("FAIL bypass_latency_%0d resp_valid=%b want=1", i, bus.resp_valid_o);
        end
      end
      get_resp(d, t);
      e = sb.pop_front();
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL bypass_%0d got=%h/%h want=%h/%h", i, d, t, e.data, e.tag);
      end
      total++;
      if (start_cnt - s0 !== nst[i]) begin
        bad++;
        $display("FAIL bypass_starts_%0d got=%0d want=%0d", i, start_cnt - s0, nst[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    bit stable;
    ok = 1'b0;
    stable = 1'b1;
    e.data = 32'd10; e.tag = 5'd7; sb.push_back(e);
    send(2'd1, 32'd50, 32'd5, 5'd7);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (!ok || bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== e.data ||
          bus.resp_tag_o !== e.tag || bus.req_ready_o !== 1'b0) begin
        if (stable)
          $display("FAIL bp_stable cyc=%0d vld=%b data=%h tag=%h rdy=%b want 1/%h/%h/0",
                   i, bus.resp_valid_o, bus.resp_data_o, bus.resp_tag_o, bus.req_ready_o,
                   e.data, e.tag);
        stable = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (!stable) bad++;
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_release rdy=%b vld=%b want 1/0", bus.req_ready_o, bus.resp_valid_o);
    end
  endtask

  task automatic test_kill_wait();
    exp_t e;
    logic [W-1:0] d;
    logic [TW-1:0] t;
    bit saw_resp;
    bit saw_valid;
    bit rdy_early;
    saw_resp = 1'b0;
    saw_valid = 1'b0;
    rdy_early = 1'b0;
    send(2'd1, 32'd1000, 32'd3, 5'd2);
    @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) saw_resp = 1'b1;
      if (!saw_valid && bus.req_ready_o) rdy_early = 1'b1;
      if (div_valid) saw_valid = 1'b1;
    end
    total++;
    if (saw_resp || !saw_valid || rdy_early || bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL kill_wait resp=%b core_valid=%b early_ready=%b ready=%b want 0/1/0/1",
               saw_resp, saw_valid, rdy_early, bus.req_ready_o);
    end
    e.data = 32'd3; e.tag = 5'h0A; sb.push_back(e);
    send(2'd1, 32'd9, 32'd3, 5'h0A);
    get_resp(d, t);
    e = sb.pop_front();
    total++;
    if (d !== e.data || t !== e.tag) begin
      bad++;
      $display("FAIL after_kill got=%h/%h want=%h/%h", d, t, e.data, e.tag);
    end
  endtask

  task automatic test_kill_idle_resp();
    int s0;
    s0 = start_cnt;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_op_i = 2'd1;
    bus.req_a_i = 32'd8;
    bus.req_b_i = 32'd2;
    kill = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    kill = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    total++;
    if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0 || start_cnt != s0) begin
      bad++;
      $display("FAIL kill_idle rdy=%b vld=%b starts=%0d want 1/0/0",
               bus.req_ready_o, bus.resp_valid_o, start_cnt - s0);
    end
    send(2'd0, 32'd5, 32'd0, 5'd9);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    total++;
    if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL kill_resp vld=%b rdy=%b want 0/1", bus.resp_valid_o, bus.req_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_resp;
    saw_resp = 1'b0;
    send(2'd1, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.req_ready_o !== 1'b1 ||
        {bus.resp_valid_o, start, bus.resp_data_o, bus.resp_tag_o, dn, dd} !== '0) begin
      bad++;
      $display("FAIL reset_mid rdy=%b vld=%b start=%b data=%h tag=%h n=%h d=%h want 1 then 0s",
               bus.req_ready_o, bus.resp_valid_o, start, bus.resp_data_o, bus.resp_tag_o, dn, dd);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) saw_resp = 1'b1;
    end
    total++;
    if (saw_resp) begin
      bad++;
      $display("FAIL reset_mid_resp got resp_valid=1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [W-1:0] d;
    logic [TW-1:0] t;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = -W'($urandom_range(1, 50));
      else if (sel < 6) b = W'($urandom_range(1, 1000));
      else b = $urandom;
      e.data = ref_res(op, a, b);
      e.tag = TW'(i);
      sb.push_back(e);
      send(op, a, b, TW'(i));
      get_resp(d, t);
      e = sb.pop_front();
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h got=%h/%h want=%h/%h",
                 i, op, a, b, d, t, e.data, e.tag);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 2'd0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.req_tag_i    = '0;
    bus.resp_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_signed();
    test_unsigned();
    test_bypass();
    test_backpressure();
    test_kill_wait();
    test_kill_idle_resp();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_div_seq.md
Name: int_div_seq

Overview:
- Sequencer that sits on both sides of the unsigned iterative divider core: accepts signed or unsigned DIV/REM requests from the execute stage over a valid/ready handshake.
- Normalises operands to magnitudes and launches the core with a one-cycle start pulse.
- Captures the core's quotient/remainder on its valid pulse, applies sign fix-up, and returns the result over a valid/ready response channel.
- Divide-by-zero and signed overflow bypass the core entirely.

Parameters:
- WIDTH, 32: operand/result width.
- TAG_W, 5: width of the opaque request tag, returned unchanged with the result (e.g. destination register).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; high only in IDLE
- req_op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_a_i  in  WIDTH  dividend
- req_b_i  in  WIDTH  divisor
- req_tag_i  in  TAG_W  request tag
- kill_i  in  1  flush: abandon the in-flight operation
- div_start_o  out  1  start pulse to divider core
- div_n_o  out  WIDTH  unsigned dividend to core
- div_d_o  out  WIDTH  unsigned divisor to core
- div_q_i  in  WIDTH  core quotient
- div_r_i  in  WIDTH  core remainder
- div_valid_i  in  1  core result valid, single-cycle pulse
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response accepted
- resp_data_o  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
- resp_tag_o  out  TAG_W  tag of the responding request

Behaviour:
- Reset: all registers and outputs 0; state IDLE. Consequently req_ready_o=1 after reset; all other outputs are 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: on req_valid_i, latch:
  - op and tag;
  - sign_a = signed op and a[MSB];
  - sign_b = signed op and b[MSB];
  - |a| and |b| (two's-complement negate when the sign flag is set) into div_n_o/div_d_o.
- IDLE special cases, which route IDLE -> RESP with no core activity:
  - b==0: quotient = all ones; remainder = a (raw).
  - Signed op with a==1 followed by WIDTH-1 zeros and b==all ones: quotient = a; remainder = 0.
  - Otherwise IDLE -> ISSUE.
- ISSUE: div_start_o=1 for exactly this one cycle, then -> WAIT.
- div_n_o/div_d_o are held stable from ISSUE until the core's valid pulse, because the core samples operands while idle.
- WAIT: on div_valid_i, compute the result and -> RESP:
  - quotient = (sign_a xor sign_b) ? -div_q_i : div_q_i
  - remainder = sign_a ? -div_r_i : div_r_i
  - Select the quotient or remainder per op and register it into resp_data_o.
- RESP: resp_valid_o=1 with data and tag stable until resp_ready_i; on resp_ready_i, clear resp_valid_o and -> IDLE.
- No new request is accepted in the same cycle as a response handshake; the minimum spacing is one IDLE cycle.
- Latency, req accept to resp_valid_o: 1 cycle for bypass cases; otherwise 2 + core latency (core pulse observed + 1 register).
- kill_i handling (kill_i has priority over every other event in the same cycle):
  - In ISSUE: -> DRAIN. The start pulse has already been driven this cycle, so the core must still be drained.
  - In WAIT: -> DRAIN; if div_valid_i coincides, -> IDLE and the result is discarded.
  - In RESP: drop resp_valid_o, -> IDLE.
  - In IDLE: suppresses acceptance of that cycle's request; req_ready_o stays high but no handshake occurs.
- DRAIN: wait for div_valid_i, discard the result, -> IDLE; req_ready_o=0 throughout.
- div_valid_i outside WAIT/DRAIN is ignored.
- Arithmetic: every negation is WIDTH-bit modulo; |min| = min, which the core treats correctly as an unsigned magnitude.
- Reset mid-operation: immediate return to IDLE, outputs 0. The core shares the same reset, so nothing remains in flight.

Decomposition:
- Package int_div_pkg holds:
  - enum div_op_e (DIV, DIVU, REM, REMU; 2 bits);
  - enum div_seq_state_e (IDLE, ISSUE, WAIT, RESP, DRAIN);
  - constant OP_SIGNED_MASK.
- No sub-module is instantiated; the core is external and connected at the parent level.
- The sign/magnitude and fix-up logic is two small functions in the package: abs_cond, neg_cond.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> one div_start_o; div_n_o=7, div_d_o=2; core returns q=3, r=1 -> resp_data_o=0xFFFFFFFD; REM of same -> 0xFFFFFFFF.
- DIVU a=100, b=7 -> resp_data_o=14; REMU -> 2; resp_tag_o equals req_tag_i=0x13.
- REM a=5, b=0 -> no div_start_o; resp_valid_o one cycle after accept, data=5; DIV a=5, b=0 -> 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> bypass, data=0x80000000; REM -> 0; DIVU of the same -> core launched, data=0.
- Backpressure: hold resp_ready_i=0 for 10 cycles -> resp_valid_o, data and tag stable; req_ready_o=0 until the handshake completes.
- kill_i in WAIT -> no response; req_ready_o=0 until div_valid_i; next request DIVU 9/3 -> 3.
